// File: rtl/cpu_pkg.sv
// cpu_pkg: shared defaults and enumerations for the program-counter sequencer.
//   DEF_PC_WIDTH / DEF_RESET_PC / DEF_FLUSH_CYCLES : parameter defaults
//   pc_state_t : sequencer FSM states (RUN, FLUSH)
//   pc_sel_t   : next-PC source selection
package cpu_pkg;
   localparam int DEF_PC_WIDTH = 8;
   localparam logic [7:0] DEF_RESET_PC = 8'h00;
   localparam int DEF_FLUSH_CYCLES = 2;
   typedef enum logic {RUN, FLUSH} pc_state_t;
   typedef enum logic [1:0] {SEL_INC, SEL_HOLD, SEL_BRANCH, SEL_JUMP} pc_sel_t;
endpackage

// File: rtl/pc_sequencer_redirect_select.sv
// pc_redirect_select: combinational next-PC source selection and next-PC value.
//   state            : sequencer state; requests are only honoured in RUN
//   stall            : hold the PC when no redirect is accepted
//   branch_valid/taken/immediate/next_pc : branch resolution from execute
//   jump_valid/target: jump from decode
//   pc               : current program counter
//   sel              : chosen source (branch > jump > hold > increment)
//   next_pc          : value to load on the next edge
import cpu_pkg::*;
module pc_redirect_select #(
   parameter int PW = DEF_PC_WIDTH
) (
   input  pc_state_t     state,
   input  logic          stall,
   input  logic          branch_valid,
   input  logic          branch_taken,
   input  logic [7:0]    branch_immediate,
   input  logic [PW-1:0] branch_next_pc,
   input  logic          jump_valid,
   input  logic [PW-1:0] jump_target,
   input  logic [PW-1:0] pc,
   output pc_sel_t       sel,
   output logic [PW-1:0] next_pc
);
   logic          run;
   logic [PW-1:0] branch_target;
   assign run = (state == RUN);
   // Word-addressed PC: the immediate is added unshifted and wraps modulo 2^PW,
   // so a two's-complement immediate produces a backward branch.
   assign branch_target = branch_next_pc + PW'(branch_immediate);
   always_comb begin
      sel = (run && branch_valid && branch_taken) ? SEL_BRANCH :
            (run && jump_valid)                   ? SEL_JUMP   :
            stall                                 ? SEL_HOLD   : SEL_INC;
      next_pc = (sel == SEL_BRANCH) ? branch_target :
                (sel == SEL_JUMP)   ? jump_target   :
                (sel == SEL_HOLD)   ? pc            : pc + 1'b1;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner; sequences increment, stall, branch and
// jump redirects and issues a bounded flush window after each redirect.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hold program_counter
//   branch_*          : branch resolution (target = next_pc + immediate)
//   jump_valid/target : absolute jump
//   program_counter   : registered fetch address
//   flush             : registered squash, high FLUSH_CYCLES cycles per redirect
//   redirect          : one-cycle pulse in the first flush cycle
// Optional: define BRANCH_STATS_EN to add saturating taken_count and
// not_taken_count outputs counting branches accepted in RUN.
import cpu_pkg::*;
module pc_sequencer #(
   parameter int PC_WIDTH = DEF_PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEF_RESET_PC),
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch_valid,
   input  logic                branch_taken,
   input  logic [7:0]          branch_immediate,
   input  logic [PC_WIDTH-1:0] branch_next_pc,
   input  logic                jump_valid,
   input  logic [PC_WIDTH-1:0] jump_target,
   output logic [PC_WIDTH-1:0] program_counter,
   output logic                flush,
   output logic                redirect
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]         taken_count,
   output logic [15:0]         not_taken_count
`endif
);
   pc_state_t           state, state_next;
   pc_sel_t             sel;
   logic [3:0]          cnt, cnt_next;
   logic                redirect_next;
   logic [PC_WIDTH-1:0] next_pc;

   pc_redirect_select #(.PW(PC_WIDTH)) u_select (
      .state            (state),
      .stall            (stall),
      .branch_valid     (branch_valid),
      .branch_taken     (branch_taken),
      .branch_immediate (branch_immediate),
      .branch_next_pc   (branch_next_pc),
      .jump_valid       (jump_valid),
      .jump_target      (jump_target),
      .pc               (program_counter),
      .sel              (sel),
      .next_pc          (next_pc)
   );

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      redirect_next = 1'b0;
      if (state == RUN) begin
         if (sel == SEL_BRANCH || sel == SEL_JUMP) begin
            state_next    = FLUSH;
            cnt_next      = 4'(FLUSH_CYCLES);
            redirect_next = 1'b1;
         end
      end else begin
         // Counter runs down regardless of stall; leaving on 1 gives exactly
         // FLUSH_CYCLES cycles of flush.
         cnt_next = cnt - 1'b1;
         if (cnt == 4'd1) state_next = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= RUN;
         cnt             <= '0;
         program_counter <= RESET_PC;
         flush           <= 1'b0;
         redirect        <= 1'b0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         program_counter <= next_pc;
         flush           <= (state_next == FLUSH);
         redirect        <= redirect_next;
      end
   end

`ifdef BRANCH_STATS_EN
   logic branch_accept;
   assign branch_accept = (state == RUN) && branch_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_count     <= '0;
         not_taken_count <= '0;
      end else if (branch_accept) begin
         if (branch_taken && taken_count != 16'hFFFF) taken_count <= taken_count + 1'b1;
         if (!branch_taken && not_taken_count != 16'hFFFF) not_taken_count <= not_taken_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with directed and random stimulus.
module tb_pc_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       branch_valid = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_immediate = '0;
   logic [7:0] branch_next_pc = '0;
   logic       jump_valid = 1'b0;
   logic [7:0] jump_target = '0;
   logic [7:0] program_counter;
   logic       flush;
   logic       redirect;
`ifdef BRANCH_STATS_EN
   logic [15:0] taken_count, not_taken_count;
`endif

   pc_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .branch_valid     (branch_valid),
      .branch_taken     (branch_taken),
      .branch_immediate (branch_immediate),
      .branch_next_pc   (branch_next_pc),
      .jump_valid       (jump_valid),
      .jump_target      (jump_target),
      .program_counter  (program_counter),
      .flush            (flush),
      .redirect         (redirect)
`ifdef BRANCH_STATS_EN
      ,
      .taken_count      (taken_count),
      .not_taken_count  (not_taken_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pc;
      logic        fl;
      logic        rd;
      logic [15:0] tc;
      logic [15:0] ntc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state: PC, remaining flush cycles, branch statistics.
   logic [7:0]  m_pc;
   int          m_left;
   logic [15:0] m_tc, m_ntc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a new registered result; compare
   // it against the oldest outstanding expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("program_counter", 32'(program_counter), 32'(e.pc));
         check("flush", 32'(flush), 32'(e.fl));
         check("redirect", 32'(redirect), 32'(e.rd));
`ifdef BRANCH_STATS_EN
         check("taken_count", 32'(taken_count), 32'(e.tc));
         check("not_taken_count", 32'(not_taken_count), 32'(e.ntc));
`endif
      end
   end

   task automatic model_reset();
      m_pc = 8'h00; m_left = 0; m_tc = '0; m_ntc = '0;
   endtask

   // Drives one cycle of requests at the falling edge, predicts the result of
   // the next rising edge and queues it, then advances to the next falling edge.
   task automatic step(input logic bv, input logic bt, input logic [7:0] bnpc,
                       input logic [7:0] imm, input logic jv, input logic [7:0] jt,
                       input logic st);
      exp_t e;
      logic rd;
      branch_valid = bv; branch_taken = bt; branch_next_pc = bnpc;
      branch_immediate = imm; jump_valid = jv; jump_target = jt; stall = st;
      rd = 1'b0;
      if (m_left == 0) begin
         if (bv && bt) begin m_pc = bnpc + imm; rd = 1'b1; end
         else if (jv) begin m_pc = jt; rd = 1'b1; end
         else if (!st) m_pc = m_pc + 8'd1;
         if (bv && bt && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
         if (bv && !bt && m_ntc != 16'hFFFF) m_ntc = m_ntc + 16'd1;
         if (rd) m_left = 2;
      end else begin
         if (!st) m_pc = m_pc + 8'd1;
         m_left = m_left - 1;
      end
      e.pc = m_pc; e.fl = (m_left > 0); e.rd = rd; e.tc = m_tc; e.ntc = m_ntc;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      branch_valid = 0; jump_valid = 0; stall = 0;
      rst_n = 1'b0;
      #1;
      check("reset_pc", 32'(program_counter), 32'h00);
      check("reset_flush", 32'(flush), 32'h0);
      check("reset_redirect", 32'(redirect), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();
      idle(2);
      step(1, 1, 8'h10, 8'h05, 0, 8'h00, 0);
      idle(3);
      step(1, 1, 8'h02, 8'hFC, 0, 8'h00, 1);
      idle(4);
      step(1, 1, 8'h3F, 8'h01, 1, 8'h80, 0);
      idle(3);
      step(1, 0, 8'h3F, 8'h01, 1, 8'h80, 0);
      idle(3);
      step(0, 0, 8'h00, 8'h00, 1, 8'h20, 0);
      step(1, 1, 8'h70, 8'h07, 1, 8'h90, 0);
      idle(3);
      step(0, 0, 8'h00, 8'h00, 1, 8'h50, 0);
      do_reset();
      idle(3);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
              8'($urandom), $urandom_range(0, 4) == 0, 8'($urandom),
              $urandom_range(0, 3) == 0);
      do_reset();
      idle(2);
      @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the CPU's 8-bit word-addressed program counter and sequences every change to it: sequential increment, stall hold, taken-branch redirect and jump redirect.
- Computes branch targets internally as next-PC plus immediate.
- Issues a bounded flush window to the front-end after each redirect.
- Sits between the fetch stage (consumes program_counter and flush) and the decode/execute stages (supply branch and jump resolutions).

Parameters:
- PC_WIDTH, 8, width of program counter and all address ports.
- RESET_PC, 8'h00, value loaded into program_counter on reset.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold program_counter; no increment.
- branch_valid  input  1  a conditional branch resolves in execute this cycle.
- branch_taken  input  1  resolution outcome; qualified by branch_valid.
- branch_immediate  input  8  raw immediate field of the branch.
- branch_next_pc  input  PC_WIDTH  next-instruction PC of the branch (branch PC + 1).
- jump_valid  input  1  unconditional jump decoded this cycle.
- jump_target  input  PC_WIDTH  absolute jump destination.
- program_counter  output  PC_WIDTH  current fetch address (registered).
- flush  output  1  squash younger in-flight instructions (registered).
- redirect  output  1  one-cycle pulse in the cycle after program_counter is loaded from a target.

Behaviour:
- Interface (decided): single clock clk; reset rst_n asynchronous, active-low.
- Reset values: program_counter = RESET_PC; flush = 0; redirect = 0; state = RUN; flush counter = 0.
- Branch target = branch_next_pc + branch_immediate, modulo 2^PC_WIDTH.
  - No shift; the PC is word-addressed.
  - A two's-complement immediate yields backward branches through wrap, e.g. 8'h05 + 8'hFE = 8'h03.
- Sequential increment: program_counter + 1 modulo 256 (8'hFF -> 8'h00).
- FSM states are RUN and FLUSH.
- RUN, redirect priority:
  1. branch_valid & branch_taken loads the branch target (older instruction, wins over a jump).
  2. Else jump_valid loads jump_target.
  3. Else if stall, hold.
  4. Else increment.
  - Any redirect goes to FLUSH with counter = FLUSH_CYCLES, sets flush = 1 and redirect = 1 on the next edge.
- Redirect overrides stall; stall never blocks a redirect.
- branch_valid with branch_taken = 0 in the same cycle as jump_valid: the jump applies.
- FLUSH:
  - branch_valid and jump_valid are ignored (wrong-path).
  - The counter decrements every cycle, independent of stall.
  - program_counter follows the stall/increment rule.
  - When the counter reaches 1, the next edge returns to RUN with flush = 0.
  - flush is high for exactly FLUSH_CYCLES cycles.
- redirect is high only in the first FLUSH cycle.
- Latency: a redirect request in cycle N appears on program_counter in cycle N+1.
- Reset asserted mid-FLUSH aborts immediately to reset values; no residual flush.
- Inputs are sampled only on clk; no combinational input->output path.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs taken_count[15:0] and not_taken_count[15:0].
  - They increment on accepted (RUN-state) branch_valid by outcome.
  - They saturate at 16'hFFFF and reset to 0.
  - Branches ignored during FLUSH are not counted.
- Undefined: the ports and counters are absent; the core behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_WIDTH, RESET_PC and FLUSH_CYCLES defaults.
  - An enum pc_state_t {RUN, FLUSH}.
  - A 2-bit enum pc_sel_t {SEL_INC, SEL_HOLD, SEL_BRANCH, SEL_JUMP}.
- One combinational sub-module, pc_redirect_select:
  - Inputs: request signals and state.
  - Outputs: pc_sel_t and the computed next-PC.
  - The sequencer keeps all registers and the FSM.

Test Plan:
- Reset release: rst_n low then high, no requests, stall = 0 -> program_counter 8'h00, 8'h01, 8'h02 on successive cycles; flush = 0.
- Forward branch: branch_valid = 1, taken = 1, branch_next_pc = 8'h10, imm = 8'h05 -> program_counter = 8'h15 next cycle; redirect pulses 1 cycle; flush high exactly 2 cycles.
- Backward branch with wrap and stall: branch_next_pc = 8'h02, imm = 8'hFC, stall = 1 in same cycle -> program_counter = 8'hFE; then stall = 0 -> 8'hFF, 8'h00.
- Simultaneous branch and jump: taken branch (target 8'h40) plus jump_valid (jump_target 8'h80) -> 8'h40; repeat with branch_taken = 0 -> 8'h80.
- Wrong-path suppression: jump to 8'h20, then jump_valid to 8'h90 during the flush window -> ignored, PC continues 8'h21, 8'h22. Same case with BRANCH_STATS_EN defined and a taken branch during the window -> taken_count unchanged.
- Reset mid-flush: assert rst_n = 0 one cycle after a redirect -> program_counter = 8'h00 and flush = 0 asynchronously; after release, normal increment with no flush.
